sfr_bit_engine: RTL and testbench

SFR_BIT_ENGINE -- requirements
Module: sfr_bit_engine

---
 rtl/sfr_bit_engine.sv | 170 +++++++++++++++++
 tb/tb_sfr_bit_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfr_bit_engine.sv
// sfr_bit_engine: 8051 bit-operation engine (SETB/CLR/CPL/MOV/ANL/ORL/TEST).
// One operation takes four cycles: IDLE -> READ -> EXEC -> WRITE -> IDLE.
// Optional build macro: SFR_BIT_ENGINE_NEG_EN. When it is defined, op_neg
// complements the bit operand of ANL C,bit and ORL C,bit.
module sfr_bit_engine (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       op_neg,
  input  logic [7:0] bit_addr,
  input  logic       carry,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  output logic       wr_en,
  output logic       wr_bit_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wr_bit,
  output logic       carry_out,
  output logic [1:0] psw_set,
  output logic       bit_value
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  // Flag-update request codes shared with the PSW block.
  localparam logic [1:0] PSW_NONE   = 2'b00;
  localparam logic [1:0] PSW_CY_SET = 2'b01;

`ifdef SFR_BIT_ENGINE_NEG_EN
  localparam logic NEG_EN = 1'b1;
`else
  localparam logic NEG_EN = 1'b0;
`endif

  state_t     state_q, state_d;

  logic [2:0] op_q;
  logic       neg_q;
  logic [7:0] addr_q;
  logic       carry_q;

  logic       wr_en_q, wr_bit_en_q, wr_bit_q, carry_out_q, bit_value_q;
  logic [7:0] wr_addr_q, wr_data_q;
  logic [1:0] psw_set_q;

  logic [7:0] byte_addr;
  logic [2:0] bit_idx;
  logic       rd_bit;
  logic       operand;
  logic       new_bit;
  logic       new_carry;
  logic [7:0] byte_new;
  logic       is_write_op;
  logic       is_carry_op;

  // Decode the captured bit address into the byte address and bit index.
  always_comb begin
    bit_idx = addr_q[2:0];
    if (addr_q[7]) byte_addr = {addr_q[7:3], 3'b000};
    else           byte_addr = 8'h20 + {4'h0, addr_q[6:3]};
  end

  // Compute the new bit / carry / byte from the read data during EXEC.
  always_comb begin
    rd_bit      = rd_data[bit_idx];
    is_write_op = (op_q <= 3'd3);
    is_carry_op = (op_q >= 3'd4) && (op_q <= 3'd6);
    operand     = rd_bit ^ (NEG_EN & neg_q & ((op_q == 3'd5) || (op_q == 3'd6)));
    case (op_q)
      3'd0:    new_bit = 1'b1;
      3'd1:    new_bit = 1'b0;
      3'd2:    new_bit = ~rd_bit;
      3'd3:    new_bit = carry_q;
      default: new_bit = 1'b0;
    endcase
    case (op_q)
      3'd4:    new_carry = rd_bit;
      3'd5:    new_carry = carry_q & operand;
      3'd6:    new_carry = carry_q | operand;
      default: new_carry = carry_q;
    endcase
    byte_new = rd_data;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i == 32'(bit_idx)) byte_new[i] = new_bit;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status and read-port outputs decoded from the state register.
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == WRITE);
    rd_en   = (state_q == READ);
    rd_addr = rd_en ? byte_addr : '0;
  end

  // Operand capture and registered write/flag outputs; strobes last one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q        <= '0;
      neg_q       <= 1'b0;
      addr_q      <= '0;
      carry_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_bit_en_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_bit_q    <= 1'b0;
      carry_out_q <= 1'b0;
      psw_set_q   <= PSW_NONE;
      bit_value_q <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      wr_bit_en_q <= 1'b0;
      psw_set_q   <= PSW_NONE;
      if (state_q == IDLE && start) begin
        op_q    <= op;
        neg_q   <= op_neg;
        addr_q  <= bit_addr;
        carry_q <= carry;
      end
      if (state_q == EXEC) begin
        bit_value_q <= rd_bit;
        if (is_write_op) begin
          wr_en_q     <= 1'b1;
          wr_bit_en_q <= addr_q[7];
          wr_addr_q   <= addr_q[7] ? addr_q : byte_addr;
          wr_data_q   <= byte_new;
          wr_bit_q    <= new_bit;
        end
        if (is_carry_op) begin
          psw_set_q   <= PSW_CY_SET;
          carry_out_q <= new_carry;
        end
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_bit_en = wr_bit_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_bit    = wr_bit_q;
  assign carry_out = carry_out_q;
  assign psw_set   = psw_set_q;
  assign bit_value = bit_value_q;

endmodule

// File: tb/tb_sfr_bit_engine.sv
// Directed testbench for sfr_bit_engine. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_sfr_bit_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic       op_neg = 1'b0;
  logic [7:0] bit_addr = '0;
  logic       carry = 1'b0;
  logic [7:0] rd_data = '0;
  logic       busy, done, rd_en, wr_en, wr_bit_en, wr_bit, carry_out, bit_value;
  logic [7:0] rd_addr, wr_addr, wr_data;
  logic [1:0] psw_set;

  int nchk  = 0;
  int nfail = 0;

  localparam logic [1:0] PSW_NONE   = 2'b00;
  localparam logic [1:0] PSW_CY_SET = 2'b01;

`ifdef SFR_BIT_ENGINE_NEG_EN
  localparam logic ORL_NEG_EXP = 1'b1;
`else
  localparam logic ORL_NEG_EXP = 1'b0;
`endif

  sfr_bit_engine dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .op_neg(op_neg),
    .bit_addr(bit_addr), .carry(carry), .rd_data(rd_data),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_bit_en(wr_bit_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_bit(wr_bit), .carry_out(carry_out), .psw_set(psw_set), .bit_value(bit_value)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request so it is accepted on the next rising edge, then
  // return in the READ cycle with start dropped and rd_data applied.
  task automatic launch(input logic [2:0] o, input logic n, input logic [7:0] a,
                        input logic c, input logic [7:0] rd);
    @(negedge clock);
    start = 1'b1; op = o; op_neg = n; bit_addr = a; carry = c;
    @(negedge clock);
    start = 1'b0; rd_data = rd;
  endtask

  int done_cnt;
  int first_done;
  int second_done;
  logic wr_seen, psw_seen;

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_rd_en", 8'(rd_en), 8'h0);
    chk("rst_rd_addr", rd_addr, 8'h00);
    chk("rst_wr_en", 8'(wr_en), 8'h0);
    chk("rst_wr_bit_en", 8'(wr_bit_en), 8'h0);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_wr_bit", 8'(wr_bit), 8'h0);
    chk("rst_carry_out", 8'(carry_out), 8'h0);
    chk("rst_psw_set", 8'(psw_set), 8'(PSW_NONE));
    chk("rst_bit_value", 8'(bit_value), 8'h0);
    reset = 1'b0;

    // SETB 0xD5 (SFR PSW.5), read 0x00
    launch(3'd0, 1'b0, 8'hD5, 1'b0, 8'h00);
    chk("setb_rd_en", 8'(rd_en), 8'h1);
    chk("setb_rd_addr", rd_addr, 8'hD0);
    chk("setb_busy", 8'(busy), 8'h1);
    chk("setb_read_done", 8'(done), 8'h0);
    @(negedge clock); // EXEC
    chk("setb_exec_rd_en", 8'(rd_en), 8'h0);
    chk("setb_exec_wr_en", 8'(wr_en), 8'h0);
    chk("setb_exec_done", 8'(done), 8'h0);
    @(negedge clock); // WRITE
    chk("setb_wr_en", 8'(wr_en), 8'h1);
    chk("setb_wr_bit_en", 8'(wr_bit_en), 8'h1);
    chk("setb_wr_addr", wr_addr, 8'hD5);
    chk("setb_wr_bit", 8'(wr_bit), 8'h1);
    chk("setb_wr_data", wr_data, 8'h20);
    chk("setb_done", 8'(done), 8'h1);
    chk("setb_psw", 8'(psw_set), 8'(PSW_NONE));
    chk("setb_bit_value", 8'(bit_value), 8'h0);
    @(negedge clock); // IDLE
    chk("setb_idle_wr_en", 8'(wr_en), 8'h0);
    chk("setb_idle_wr_bit_en", 8'(wr_bit_en), 8'h0);
    chk("setb_idle_done", 8'(done), 8'h0);
    chk("setb_idle_busy", 8'(busy), 8'h0);

    // CPL 0x0B (RAM 0x21 bit 3), read 0xFF; inputs changed after capture
    launch(3'd2, 1'b0, 8'h0B, 1'b0, 8'hFF);
    bit_addr = 8'h00; op = 3'd0;
    #1;
    chk("cpl_rd_addr", rd_addr, 8'h21);
    @(negedge clock);
    @(negedge clock); // WRITE
    chk("cpl_wr_en", 8'(wr_en), 8'h1);
    chk("cpl_wr_bit_en", 8'(wr_bit_en), 8'h0);
    chk("cpl_wr_addr", wr_addr, 8'h21);
    chk("cpl_wr_bit", 8'(wr_bit), 8'h0);
    chk("cpl_wr_data", wr_data, 8'hF7);
    chk("cpl_bit_value", 8'(bit_value), 8'h1);

    // CLR 0x7F (RAM 0x2F bit 7), read 0x80
    launch(3'd1, 1'b0, 8'h7F, 1'b1, 8'h80);
    chk("clr_rd_addr", rd_addr, 8'h2F);
    repeat (2) @(negedge clock);
    chk("clr_wr_addr", wr_addr, 8'h2F);
    chk("clr_wr_data", wr_data, 8'h00);
    chk("clr_wr_bit", 8'(wr_bit), 8'h0);

    // MOV 0x92,C with carry 1 (SFR 0x90 bit 2), read 0x00
    launch(3'd3, 1'b0, 8'h92, 1'b1, 8'h00);
    chk("movbc_rd_addr", rd_addr, 8'h90);
    repeat (2) @(negedge clock);
    chk("movbc_wr_en", 8'(wr_en), 8'h1);
    chk("movbc_wr_bit_en", 8'(wr_bit_en), 8'h1);
    chk("movbc_wr_addr", wr_addr, 8'h92);
    chk("movbc_wr_data", wr_data, 8'h04);
    chk("movbc_wr_bit", 8'(wr_bit), 8'h1);
    chk("movbc_psw", 8'(psw_set), 8'(PSW_NONE));

    // ANL C,0xE0 with carry 1, read 0xFE
    launch(3'd5, 1'b0, 8'hE0, 1'b1, 8'hFE);
    chk("anl_rd_addr", rd_addr, 8'hE0);
    @(negedge clock);
    chk("anl_exec_psw", 8'(psw_set), 8'(PSW_NONE));
    @(negedge clock);
    chk("anl_carry_out", 8'(carry_out), 8'h0);
    chk("anl_psw", 8'(psw_set), 8'(PSW_CY_SET));
    chk("anl_wr_en", 8'(wr_en), 8'h0);
    chk("anl_done", 8'(done), 8'h1);
    @(negedge clock);
    chk("anl_idle_psw", 8'(psw_set), 8'(PSW_NONE));

    // ORL C,/0xE0 with carry 0, read 0xFE, op_neg 1
    launch(3'd6, 1'b1, 8'hE0, 1'b0, 8'hFE);
    repeat (2) @(negedge clock);
    chk("orln_carry_out", 8'(carry_out), 8'(ORL_NEG_EXP));
    chk("orln_psw", 8'(psw_set), 8'(PSW_CY_SET));
    chk("orln_wr_en", 8'(wr_en), 8'h0);

    // MOV C,0x0B with op_neg 1 (ignored for MOV), read 0x08
    launch(3'd4, 1'b1, 8'h0B, 1'b0, 8'h08);
    repeat (2) @(negedge clock);
    chk("movcb_carry_out", 8'(carry_out), 8'h1);
    chk("movcb_psw", 8'(psw_set), 8'(PSW_CY_SET));
    chk("movcb_bit_value", 8'(bit_value), 8'h1);
    chk("movcb_wr_en", 8'(wr_en), 8'h0);

    // Start re-pulsed during EXEC is neither honoured nor queued
    launch(3'd0, 1'b0, 8'h30, 1'b0, 8'h00);
    @(negedge clock); // EXEC
    start = 1'b1;
    @(negedge clock); // WRITE
    start = 1'b0;
    chk("rep_done", 8'(done), 8'h1);
    chk("rep_wr_data", wr_data, 8'h01);
    @(negedge clock);
    chk("rep_idle_busy", 8'(busy), 8'h0);
    chk("rep_idle_done", 8'(done), 8'h0);
    @(negedge clock);
    chk("rep_noqueue_busy", 8'(busy), 8'h0);
    chk("rep_noqueue_rd_en", 8'(rd_en), 8'h0);

    // Reset in the middle of an operation (EXEC)
    launch(3'd0, 1'b0, 8'hD3, 1'b1, 8'h00);
    @(negedge clock); // EXEC
    reset = 1'b1;
    #1;
    chk("mrst_busy", 8'(busy), 8'h0);
    chk("mrst_wr_addr", wr_addr, 8'h00);
    @(negedge clock);
    chk("mrst_wr_en", 8'(wr_en), 8'h0);
    chk("mrst_done", 8'(done), 8'h0);
    chk("mrst_psw", 8'(psw_set), 8'(PSW_NONE));
    chk("mrst_wr_data", wr_data, 8'h00);
    chk("mrst_bit_value", 8'(bit_value), 8'h0);
    reset = 1'b0;
    // Next operation after reset: SETB 0x87 (SFR 0x80 bit 7), read 0x01
    launch(3'd0, 1'b0, 8'h87, 1'b0, 8'h01);
    chk("post_rd_addr", rd_addr, 8'h80);
    repeat (2) @(negedge clock);
    chk("post_wr_en", 8'(wr_en), 8'h1);
    chk("post_wr_data", wr_data, 8'h81);
    chk("post_done", 8'(done), 8'h1);

    // Back-to-back TEST ops with start held high: 0x21 -> RAM 0x24 bit 1
    @(negedge clock);
    done_cnt = 0; first_done = -1; second_done = -1;
    wr_seen = 1'b0; psw_seen = 1'b0;
    start = 1'b1; op = 3'd7; op_neg = 1'b0; bit_addr = 8'h21; carry = 1'b1;
    rd_data = 8'h02;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 7) start = 1'b0;
      if (wr_en) wr_seen = 1'b1;
      if (psw_set != PSW_NONE) psw_seen = 1'b1;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
        else second_done = c;
      end
    end
    chk("b2b_done_count", 8'(done_cnt), 8'd2);
    chk("b2b_first_done", 8'(first_done), 8'd3);
    chk("b2b_gap", 8'(second_done - first_done), 8'd4);
    chk("test_no_wr_en", 8'(wr_seen), 8'h0);
    chk("test_no_psw", 8'(psw_seen), 8'h0);
    chk("test_bit_value", 8'(bit_value), 8'h1);
    chk("b2b_end_busy", 8'(busy), 8'h0);
    chk("test_wr_addr_kept", wr_addr, 8'h87);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
